pc_unit: RTL and testbench

Parametrised program-counter unit for the IF stage of the RV32 pipeline. It generalises the basic PC register: configurable address width, reset vector and instruction step, plus a valid/ready fetch handshake, a sticky halt state machine and a trap redirect. It also has an optional compiled-in return-address stack (RAS) that predicts `ret` targets. It drives the instruction-memory address and takes redirect requests from IF (prediction) and EXE (resolution).

---
 rtl/pc_unit_pkg.sv | 18 +
 rtl/pc_unit_if.sv | 11 +
 rtl/pc_ras.sv | 57 +++++
 rtl/pc_unit.sv | 129 ++++++++++++
 tb/tb_pc_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// Shared encodings for the IF-stage program-counter unit: FSM states and
// next-PC source selects.
package pc_unit_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } pc_state_e;

   typedef enum logic [1:0] {
      PC_PLUS_STEP  = 2'd0,
      IF_P_T_PC     = 2'd1,
      EXE_PC_PLUS_4 = 2'd2,
      EXE_T_PC      = 2'd3
   } pc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch handshake between the PC unit (master) and instruction memory (slave).
interface pc_unit_if #(
   parameter int unsigned ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] pc;
   logic                  if_valid;
   logic                  if_ready;

   modport master (output pc, output if_valid, input if_ready);
   modport slave  (input pc, input if_valid, output if_ready);
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is ignored, push+pop replaces the top in place.
module pc_ras #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] tp_q, tp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pop_hit;

   always_comb begin
      mem_d   = mem_q;
      tp_d    = tp_q;
      cnt_d   = cnt_q;
      pop_hit = pop && (cnt_q != '0);
      if (push && pop_hit) begin
         mem_d[tp_q] = push_data;
      end else if (push) begin
         // Pointer wraps over the oldest slot; only the count saturates.
         tp_d        = tp_q + PTR_W'(1);
         mem_d[tp_d] = push_data;
         if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_hit) begin
         tp_d  = tp_q - PTR_W'(1);
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         tp_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         tp_q  <= tp_d;
         cnt_q <= cnt_d;
      end
   end

   assign top   = mem_q[tp_q];
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter: BOOT/RUN/HALT FSM, prioritised next-PC select,
// trap redirect with EPC capture. Return-address stack compiled in with PC_RAS_EN.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH   = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned           ILEN_BYTES   = 4,
   parameter int unsigned           RAS_DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pc_unit_if.master             fetch,
   input  logic                  hcf,
   input  logic                  stall,
   input  logic [1:0]            pc_sel,
   input  logic [ADDR_WIDTH-1:0] predict_target_pc,
   input  logic [ADDR_WIDTH-1:0] exe_target_pc,
   input  logic [ADDR_WIDTH-1:0] exe_pc,
   input  logic                  trap_req,
   input  logic [ADDR_WIDTH-1:0] trap_vector,
   input  logic                  ras_push,
   input  logic                  ras_pop,
   output logic                  flush,
   output logic [ADDR_WIDTH-1:0] epc,
   output logic                  halted,
   output logic                  ras_empty
);
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ILEN_BYTES);

   pc_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] epc_q, epc_d;
   logic                  if_valid_q, if_valid_d;
   logic                  flush_q, flush_d;
   logic                  halted_q, halted_d;

   logic [ADDR_WIDTH-1:0] pc_plus_step;
   logic [ADDR_WIDTH-1:0] ras_top;
   logic                  ras_is_empty;
   logic                  ras_upd;
   logic                  fire;

   assign fire = if_valid_q & fetch.if_ready & ~stall;

   always_comb begin
      pc_plus_step = pc_q + STEP;
      state_d      = state_q;
      pc_d         = pc_q;
      epc_d        = epc_q;
      flush_d      = 1'b0;
      ras_upd      = 1'b0;
      unique case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (hcf) begin
               state_d = ST_HALT;
            end else if (trap_req) begin
               pc_d    = trap_vector;
               epc_d   = exe_pc;
               flush_d = 1'b1;
            end else if (!fire) begin
               pc_d = pc_q;
            end else if (pc_sel == EXE_T_PC) begin
               pc_d    = exe_target_pc;
               flush_d = 1'b1;
            end else if (pc_sel == EXE_PC_PLUS_4) begin
               pc_d    = exe_pc + STEP;
               flush_d = 1'b1;
            end else begin
               // Only un-redirected fetches may touch the return-address stack.
               ras_upd = 1'b1;
               if (ras_pop && !ras_is_empty) pc_d = ras_top;
               else if (pc_sel == IF_P_T_PC) pc_d = predict_target_pc;
               else                          pc_d = pc_plus_step;
            end
         end
         default: state_d = ST_HALT;
      endcase
      if_valid_d = (state_d == ST_RUN);
      halted_d   = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         epc_q      <= '0;
         if_valid_q <= 1'b0;
         flush_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         if_valid_q <= if_valid_d;
         flush_q    <= flush_d;
         halted_q   <= halted_d;
      end
   end

`ifdef PC_RAS_EN
   pc_ras #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (ADDR_WIDTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_upd & ras_push),
      .pop       (ras_upd & ras_pop),
      .push_data (pc_plus_step),
      .top       (ras_top),
      .empty     (ras_is_empty)
   );
`else
   logic unused_ras;
   assign ras_is_empty = 1'b1;
   assign ras_top      = '0;
   assign unused_ras   = ^{ras_push, ras_upd, (RAS_DEPTH != 0)};
`endif

   assign fetch.pc       = pc_q;
   assign fetch.if_valid = if_valid_q;
   assign flush          = flush_q;
   assign epc            = epc_q;
   assign halted         = halted_q;
   assign ras_empty      = ras_is_empty;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_pc_unit;
   import pc_unit_pkg::*;

   localparam int unsigned   AW     = 16;
   localparam logic [AW-1:0] RV     = 16'h0100;
   localparam int unsigned   DEPTH  = 4;
   localparam int            BOOTING = 0;
   localparam int            RUNNING = 1;
   localparam int            HALTED  = 2;
`ifdef PC_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          hcf = 1'b0, stall = 1'b0, trap_req = 1'b0;
   logic          ras_push = 1'b0, ras_pop = 1'b0;
   logic [1:0]    pc_sel = PC_PLUS_STEP;
   logic [AW-1:0] predict_target_pc = '0, exe_target_pc = '0, exe_pc = '0, trap_vector = '0;
   logic          flush, halted, ras_empty;
   logic [AW-1:0] epc;

   int checks = 0;
   int failures = 0;

   pc_unit_if #(.ADDR_WIDTH(AW)) fetch_if ();

   pc_unit #(
      .ADDR_WIDTH   (AW),
      .RESET_VECTOR (RV),
      .ILEN_BYTES   (4),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .fetch             (fetch_if),
      .hcf               (hcf),
      .stall             (stall),
      .pc_sel            (pc_sel),
      .predict_target_pc (predict_target_pc),
      .exe_target_pc     (exe_target_pc),
      .exe_pc            (exe_pc),
      .trap_req          (trap_req),
      .trap_vector       (trap_vector),
      .ras_push          (ras_push),
      .ras_pop           (ras_pop),
      .flush             (flush),
      .epc               (epc),
      .halted            (halted),
      .ras_empty         (ras_empty)
   );

   always #5 clk = ~clk;

   // Behavioural reference model
   int            m_phase = BOOTING;
   logic [AW-1:0] m_pc = RV;
   logic [AW-1:0] m_epc = '0;
   logic          m_flush = 1'b0;
   logic [AW-1:0] m_ras[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = BOOTING;
         m_pc    = RV;
         m_epc   = '0;
         m_flush = 1'b0;
         m_ras.delete();
      end else begin
         logic [AW-1:0] seq, nxt;
         seq     = m_pc + 16'd4;
         m_flush = 1'b0;
         if (m_phase == BOOTING) begin
            m_phase = RUNNING;
         end else if (m_phase == RUNNING) begin
            if (hcf) begin
               m_phase = HALTED;
            end else if (trap_req) begin
               m_pc = trap_vector; m_epc = exe_pc; m_flush = 1'b1;
            end else if (stall || !fetch_if.if_ready) begin
               m_pc = m_pc;
            end else if (pc_sel == EXE_T_PC) begin
               m_pc = exe_target_pc; m_flush = 1'b1;
            end else if (pc_sel == EXE_PC_PLUS_4) begin
               m_pc = exe_pc + 16'd4; m_flush = 1'b1;
            end else begin
               nxt = (pc_sel == IF_P_T_PC) ? predict_target_pc : seq;
               if (RAS_ON) begin
                  if (ras_pop && m_ras.size() > 0) begin
                     nxt = m_ras[$];
                     if (ras_push) m_ras[m_ras.size()-1] = seq;
                     else void'(m_ras.pop_back());
                  end else if (ras_push) begin
                     m_ras.push_back(seq);
                     if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                  end
               end
               m_pc = nxt;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("pc", 32'(fetch_if.pc), 32'(m_pc));
      chk("if_valid", 32'(fetch_if.if_valid), 32'(m_phase == RUNNING));
      chk("flush", 32'(flush), 32'(m_flush));
      chk("epc", 32'(epc), 32'(m_epc));
      chk("halted", 32'(halted), 32'(m_phase == HALTED));
      chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hcf = 0; stall = 0; trap_req = 0; ras_push = 0; ras_pop = 0;
      pc_sel = PC_PLUS_STEP; fetch_if.if_ready = 1;
   endtask

   initial begin
      idle();
      #12;
      chk("rst_pc", 32'(fetch_if.pc), 32'h100);
      chk("rst_valid", 32'(fetch_if.if_valid), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_epc", 32'(epc), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_ras_empty", 32'(ras_empty), 1);
      rst_n = 1;
      step();
      chk("boot_pc", 32'(fetch_if.pc), 32'h100);
      chk("boot_valid", 32'(fetch_if.if_valid), 1);
      step(); chk("seq1", 32'(fetch_if.pc), 32'h104);
      step(); chk("seq2", 32'(fetch_if.pc), 32'h108);

      pc_sel = IF_P_T_PC; predict_target_pc = 16'h0020;
      step(); chk("pred", 32'(fetch_if.pc), 32'h20);
      chk("pred_flush", 32'(flush), 0);
      pc_sel = PC_PLUS_STEP; stall = 1;
      for (int i = 0; i < 3; i++) begin
         step(); chk("stall_hold", 32'(fetch_if.pc), 32'h20);
      end
      stall = 0; pc_sel = EXE_T_PC; exe_target_pc = 16'h0080;
      step(); chk("exe_t", 32'(fetch_if.pc), 32'h80); chk("exe_t_flush", 32'(flush), 1);
      pc_sel = PC_PLUS_STEP;
      step(); chk("after_exe", 32'(fetch_if.pc), 32'h84); chk("flush_pulse", 32'(flush), 0);

      stall = 1; trap_req = 1; trap_vector = 16'h0040; exe_pc = 16'h001C;
      step(); chk("trap_pc", 32'(fetch_if.pc), 32'h40);
      chk("trap_epc", 32'(epc), 32'h1C); chk("trap_flush", 32'(flush), 1);
      stall = 0; trap_req = 0;
      step(); chk("after_trap", 32'(fetch_if.pc), 32'h44);

      pc_sel = IF_P_T_PC; predict_target_pc = 16'hFFFC;
      step(); chk("pre_wrap", 32'(fetch_if.pc), 32'hFFFC);
      pc_sel = PC_PLUS_STEP;
      step(); chk("wrap", 32'(fetch_if.pc), 32'h0000);

      hcf = 1;
      step(); chk("halt", 32'(halted), 1); chk("halt_valid", 32'(fetch_if.if_valid), 0);
      chk("halt_pc", 32'(fetch_if.pc), 32'h0000);
      hcf = 0; trap_req = 1; trap_vector = 16'h0300;
      for (int i = 0; i < 3; i++) begin
         step(); chk("halt_frozen", 32'(fetch_if.pc), 32'h0000);
      end
      chk("halt_epc", 32'(epc), 32'h1C);
      idle();
      rst_n = 0; #1;
      chk("halt_rst_pc", 32'(fetch_if.pc), 32'h100);
      chk("halt_rst", 32'(halted), 0);
      #2; rst_n = 1;
      step();

`ifdef PC_RAS_EN
      pc_sel = IF_P_T_PC; predict_target_pc = 16'h0010;
      step();
      ras_push = 1;
      for (int k = 2; k <= 6; k++) begin
         predict_target_pc = 16'(k * 16);
         step();
      end
      chk("ras_full", 32'(ras_empty), 0);
      ras_push = 0; ras_pop = 1; pc_sel = PC_PLUS_STEP;
      step(); chk("pop1", 32'(fetch_if.pc), 32'h54);
      step(); chk("pop2", 32'(fetch_if.pc), 32'h44);
      step(); chk("pop3", 32'(fetch_if.pc), 32'h34);
      step(); chk("pop4", 32'(fetch_if.pc), 32'h24);
      chk("ras_drained", 32'(ras_empty), 1);
      step(); chk("pop5_fall", 32'(fetch_if.pc), 32'h28);
      chk("pop5_empty", 32'(ras_empty), 1);
`else
      ras_push = 1;
      step(); chk("push_ignored", 32'(ras_empty), 1);
      ras_push = 0; ras_pop = 1;
      step(); chk("pop_ignored", 32'(fetch_if.pc), 32'h108);
`endif
      idle();

      for (int n = 0; n < 3000; n++) begin
         if (!rst_n) rst_n = 1;
         else if ($urandom_range(0, 59) == 0) rst_n = 0;
         hcf               = ($urandom_range(0, 79) == 0);
         stall             = ($urandom_range(0, 3) == 0);
         fetch_if.if_ready = ($urandom_range(0, 3) != 0);
         trap_req          = ($urandom_range(0, 15) == 0);
         pc_sel            = 2'($urandom_range(0, 3));
         predict_target_pc = 16'($urandom);
         exe_target_pc     = 16'($urandom);
         exe_pc            = 16'($urandom);
         trap_vector       = 16'($urandom);
         ras_push          = ($urandom_range(0, 2) == 0);
         ras_pop           = ($urandom_range(0, 2) == 0);
         step();
      end

      @(negedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
